// File: rtl/carry_look_ahead4bit.sv
// 4-bit carry look-ahead adder with registered outputs.
// Carries are flat sum-of-products terms, so no ripple path exists.
module carry_look_ahead4bit (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout,
   input  logic       clk,
   input  logic       rst,
   output logic       PG,
   output logic       GG,
   output logic       Ovf
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;
   logic [3:0] sum_d;
   logic       pg_d;
   logic       gg_d;

   assign p = A ^ B;
   assign g = A & B;

   // Two-level carry terms; each carry sees only P, G and Cin.
   always_comb begin
      c[0] = Cin;
      c[1] = g[0]
           | (p[0] & Cin);
      c[2] = g[1]
           | (p[1] & g[0])
           | (p[1] & p[0] & Cin);
      c[3] = g[2]
           | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & Cin);
      c[4] = g[3]
           | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & Cin);
   end

   // Sum bits and group terms; group generate ignores Cin.
   always_comb begin
      sum_d = p ^ c[3:0];
      pg_d  = &p;
      gg_d  = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
   end

   // Output register; reset wins over incoming data.
   always_ff @(posedge clk) begin
      if (rst) begin
         Sum  <= 4'd0;
         Cout <= 1'b0;
         PG   <= 1'b0;
         GG   <= 1'b0;
         Ovf  <= 1'b0;
      end else begin
         Sum  <= sum_d;
         Cout <= c[4];
         PG   <= pg_d;
         GG   <= gg_d;
         Ovf  <= c[4] ^ c[3];
      end
   end

endmodule

// File: tb/tb_carry_look_ahead4bit.sv
// Directed bench for carry_look_ahead4bit.
// Expected values are hand-computed or derived from integer arithmetic.
module tb_carry_look_ahead4bit;

   logic [3:0] A;
   logic [3:0] B;
   logic       Cin;
   logic [3:0] Sum;
   logic       Cout;
   logic       clk;
   logic       rst;
   logic       PG;
   logic       GG;
   logic       Ovf;

   int errors = 0;
   int checks = 0;

   carry_look_ahead4bit dut (
      .A    (A),
      .B    (B),
      .Cin  (Cin),
      .Sum  (Sum),
      .Cout (Cout),
      .clk  (clk),
      .rst  (rst),
      .PG   (PG),
      .GG   (GG),
      .Ovf  (Ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] full;
      logic [3:0] sa;
      logic [3:0] sb;
      logic       sc;
      logic [3:0] hs;
      logic       hc;

      // reset with all-ones inputs
      rst = 1'b1;
      A   = 4'hF;
      B   = 4'hF;
      Cin = 1'b1;
      tick();
      tick();
      check("rst_sum",  {4'd0, Sum}, 8'h00);
      check("rst_cout", {7'd0, Cout}, 8'h00);
      check("rst_pg",   {7'd0, PG}, 8'h00);
      check("rst_gg",   {7'd0, GG}, 8'h00);
      check("rst_ovf",  {7'd0, Ovf}, 8'h00);

      // exhaustive sweep, one vector per cycle
      rst = 1'b0;
      for (int ci = 0; ci < 2; ci++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               sa  = 4'(a);
               sb  = 4'(b);
               sc  = 1'(ci);
               A   = sa;
               B   = sb;
               Cin = sc;
               full = 5'(a + b + ci);
               tick();
               check("sweep_sum", {3'd0, Cout, Sum}, {3'd0, full});
               check("sweep_pg", {7'd0, PG},
                     {7'd0, ((sa ^ sb) == 4'hF)});
               check("sweep_gg", {7'd0, GG},
                     {7'd0, ((a + b) > 15)});
               check("sweep_ovf", {7'd0, Ovf},
                     {7'd0, (sa[3] == sb[3]) && (full[3] != sa[3])});
            end
         end
      end

      // full propagate: 5 + ~5 + 1
      A   = 4'h5;
      B   = 4'hA;
      Cin = 1'b1;
      tick();
      check("prop_sum",  {4'd0, Sum}, 8'h00);
      check("prop_cout", {7'd0, Cout}, 8'h01);
      check("prop_pg",   {7'd0, PG}, 8'h01);
      check("prop_gg",   {7'd0, GG}, 8'h00);
      check("prop_ovf",  {7'd0, Ovf}, 8'h00);

      // positive overflow without carry-out
      A   = 4'h7;
      B   = 4'h1;
      Cin = 1'b0;
      tick();
      check("ovf1_sum",  {4'd0, Sum}, 8'h08);
      check("ovf1_cout", {7'd0, Cout}, 8'h00);
      check("ovf1_ovf",  {7'd0, Ovf}, 8'h01);
      check("ovf1_gg",   {7'd0, GG}, 8'h00);

      // negative overflow with generate
      A   = 4'h8;
      B   = 4'h8;
      Cin = 1'b0;
      tick();
      check("ovf2_sum",  {4'd0, Sum}, 8'h00);
      check("ovf2_cout", {7'd0, Cout}, 8'h01);
      check("ovf2_ovf",  {7'd0, Ovf}, 8'h01);
      check("ovf2_gg",   {7'd0, GG}, 8'h01);

      // reset mid-stream discards 3 + 4
      A   = 4'h3;
      B   = 4'h4;
      Cin = 1'b0;
      rst = 1'b1;
      tick();
      check("mid_sum",  {4'd0, Sum}, 8'h00);
      check("mid_cout", {7'd0, Cout}, 8'h00);
      check("mid_gg",   {7'd0, GG}, 8'h00);
      check("mid_ovf",  {7'd0, Ovf}, 8'h00);
      rst = 1'b0;
      tick();
      check("rel_sum",  {4'd0, Sum}, 8'h07);
      check("rel_cout", {7'd0, Cout}, 8'h00);

      // outputs hold while inputs move between edges
      A   = 4'h1;
      B   = 4'h2;
      Cin = 1'b0;
      tick();
      hs  = Sum;
      hc  = Cout;
      check("hold_pre", {3'd0, hc, hs}, 8'h03);
      A   = 4'hF;
      B   = 4'hF;
      Cin = 1'b1;
      #3;
      check("hold_sum",  {4'd0, Sum}, 8'h03);
      check("hold_cout", {7'd0, Cout}, 8'h00);
      tick();
      check("hold_new", {3'd0, Cout, Sum}, 8'h1F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/carry_look_ahead4bit.md
CARRY_LOOK_AHEAD4BIT -- requirements
Module: carry_look_ahead4bit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Port: clk, input, 1 bit; the only clock; all state updates on its rising edge.
REQ-003 Port: rst, input, 1 bit; synchronous, active-high reset.
REQ-004 Port: A, input, 4 bits; unsigned addend; bit 0 is the LSB.
REQ-005 Port: B, input, 4 bits; unsigned addend; bit 0 is the LSB.
REQ-006 Port: Cin, input, 1 bit; carry-in to bit 0.
REQ-007 Port: Sum, output, 4 bits; registered A+B+Cin, modulo 16.
REQ-008 Port: Cout, output, 1 bit; registered carry-out of bit 3.
REQ-009 Port: PG, output, 1 bit; registered group propagate, P3&P2&P1&P0.
REQ-010 Port: GG, output, 1 bit; registered group generate.
REQ-011 Port: Ovf, output, 1 bit; registered two's-complement overflow, c4 XOR c3.
REQ-012 Port declaration order SHALL be A, B, Cin, Sum, Cout, clk, rst, PG, GG, Ovf, so that positional instantiation of the first five ports works.

Function
REQ-013 Per-bit terms SHALL be Pi = Ai XOR Bi and Gi = Ai AND Bi, for i = 0..3.
REQ-014 Carries SHALL be computed in parallel as two-level sum-of-products; no ripple chain is allowed:
- c0 = Cin
- c1 = G0 | P0c0
- c2 = G1 | P1G0 | P1P0c0
- c3 = G2 | P2G1 | P2P1G0 | P2P1P0c0
- c4 = G3 | P3G2 | P3P2G1 | P3P2P1G0 | P3P2P1P0c0
REQ-015 Sum bits SHALL be Si = Pi XOR ci; the carry-out SHALL be c4.
REQ-016 Group generate SHALL be GG = G3 | P3G2 | P3P2G1 | P3P2P1G0; GG does not depend on Cin.
REQ-017 Combinational results SHALL be sampled on the rising edge of clk, giving a latency of exactly one cycle from input to output.
REQ-018 Inputs SHALL be sampled every cycle; there is no enable and no handshake.
REQ-019 The full result {Cout, Sum} SHALL equal A + B + Cin, which ranges from 0 to 31, for all 512 input combinations.
REQ-020 Outputs SHALL hold their values between rising clock edges regardless of input changes.
REQ-021 Inputs that are X or Z produce undefined results; no checking of such inputs is required.

Reset
REQ-022 While rst = 1 at a rising edge, Sum, Cout, PG, GG and Ovf SHALL all be 0 after that edge.
REQ-023 Reset SHALL have priority over new input data.
REQ-024 Results SHALL resume on the first rising edge with rst = 0, using the inputs sampled at that edge.
REQ-025 Asserting reset mid-stream SHALL discard the pending result with no partial update.
REQ-026 Before the first clock edge, outputs are undefined; the bench SHALL apply reset first.

Verification
REQ-027 Reset check: apply rst = 1 for 2 cycles with A = F, B = F, Cin = 1 -> Sum = 0, Cout = 0, PG = 0, GG = 0, Ovf = 0.
REQ-028 Exhaustive check: sweep A, B = 0..15 with Cin = 0, then again with Cin = 1, one vector per cycle -> one cycle later, {Cout, Sum} = A + B + Cin for all 512 vectors.
REQ-029 Full propagate: A = 5, B = A, Cin = 1 -> Sum = 0, Cout = 1, PG = 1, GG = 0, Ovf = 0.
REQ-030 Generate and overflow: A = 7, B = 1, Cin = 0 -> Sum = 8, Cout = 0, Ovf = 1, GG = 0; then A = 8, B = 8, Cin = 0 -> Sum = 0, Cout = 1, Ovf = 1, GG = 1.
REQ-031 Reset mid-stream: present A = 3, B = 4 and assert rst on the same edge -> outputs are 0; release rst -> Sum = 7 one cycle after the release edge.
REQ-032 Hold check: change the inputs between clock edges -> Sum and Cout do not change until the next rising edge.
